shift_operand_stage: RTL and testbench

- Registered issue stage directly upstream of the ALU shift units (logical left, logical right, arithmetic right).
- Accepts decoded shift instructions plus register-file operands through a valid/ready handshake.
- Resolves the operand to shift, the 32-bit shift amount, direction, arithmetic/logical mode and the over-range flag.
- Presents the result to the shifter through a 2-entry skid buffer, so upstream stalls never drop or duplicate an operation.

---
 rtl/shift_operand_stage.sv | 100 ++++++++++
 tb/tb_shift_operand_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_stage.sv
// shift_operand_stage: decodes shift instructions into operand/amount/mode fields
// and hands them to the shifter through a registered 2-entry skid buffer.
module shift_operand_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_funct,
   input  logic [31:0] in_rs,
   input  logic [31:0] in_rt,
   input  logic [4:0]  in_shamt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic        out_dir,
   output logic        out_arith,
   output logic        out_sat,
   output logic        illegal
);
   if (DEPTH != 2) begin : g_bad_depth
      $error("shift_operand_stage supports DEPTH == 2 only");
   end

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        dir;
      logic        arith;
      logic        sat;
   } entry_t;

   entry_t     main_q, main_d, skid_q, skid_d, new_e;
   logic [1:0] count_q, count_d;
   logic       in_ready_q, illegal_q, illegal_d;
   logic       acc, bad_code, push, pop;

   assign bad_code = in_funct[1:0] == 2'b01;
   assign acc      = in_valid & in_ready;
   assign push     = acc & ~bad_code;
   assign pop      = out_valid & out_ready;

   assign new_e.a     = in_rt;
   assign new_e.b     = in_funct[2] ? in_rs : {27'b0, in_shamt};
   assign new_e.dir   = ~in_funct[1];
   assign new_e.arith = in_funct[1:0] == 2'b11;
   assign new_e.sat   = in_funct[2] & (|in_rs[31:5]);

   // Simultaneous push/pop at count 2 cannot happen (in_ready is low), but is kept coherent anyway.
   always_comb begin
      main_d  = main_q;
      skid_d  = skid_q;
      count_d = count_q;
      if (push && pop) begin
         if (count_q == 2'd2) begin
            main_d = skid_q;
            skid_d = new_e;
         end else begin
            main_d = new_e;
         end
      end else if (push) begin
         if (count_q == 2'd0) main_d = new_e;
         else skid_d = new_e;
         count_d = count_q + 2'd1;
      end else if (pop) begin
         main_d  = skid_q;
         count_d = count_q - 2'd1;
      end
   end

   assign illegal_d = acc & bad_code;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
         illegal_q  <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         count_q    <= count_d;
         in_ready_q <= count_d != 2'd2;
         illegal_q  <= illegal_d;
      end
   end

   // Held low while rst is asserted so nothing is accepted during the reset cycle.
   assign in_ready  = in_ready_q & ~rst;
   assign out_valid = |count_q;
   assign out_a     = main_q.a;
   assign out_b     = main_q.b;
   assign out_dir   = main_q.dir;
   assign out_arith = main_q.arith;
   assign out_sat   = main_q.sat;
   assign illegal   = illegal_q;
endmodule

// File: tb/tb_shift_operand_stage.sv
// tb_shift_operand_stage: directed stimulus with hand-computed expectations
// for the shift operand stage.
module tb_shift_operand_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [4:0]  in_shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic        out_dir;
   logic        out_arith;
   logic        out_sat;
   logic        illegal;
   int          n_chk = 0;
   int          n_fail = 0;

   shift_operand_stage #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_dir(out_dir), .out_arith(out_arith), .out_sat(out_sat), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic op(input logic v, input logic [2:0] f, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [4:0] sh);
      in_valid = v;
      in_funct = f;
      in_rs    = rs;
      in_rt    = rt;
      in_shamt = sh;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic dir, input logic arith, input logic sat);
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".a"}, out_a, a);
      chk({tag, ".b"}, out_b, b);
      chk({tag, ".dir"}, {31'b0, out_dir}, {31'b0, dir});
      chk({tag, ".arith"}, {31'b0, out_arith}, {31'b0, arith});
      chk({tag, ".sat"}, {31'b0, out_sat}, {31'b0, sat});
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      cyc();
      cyc();
      smp();
      chk("rst.in_ready_during", {31'b0, in_ready}, 32'd0);
      cyc();
      rst = 1'b0;
      smp();
      chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst.out_a", out_a, 32'd0);
      chk("rst.out_b", out_b, 32'd0);
      chk("rst.flags", {28'b0, out_dir, out_arith, out_sat, illegal}, 32'd0);

      // sra immediate, 1-cycle latency
      cyc();
      out_ready = 1'b1;
      op(1'b1, 3'b011, 32'd0, 32'h8000_0010, 5'd4);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk_out("sra", 32'h8000_0010, 32'd4, 1'b0, 1'b1, 1'b0);
      cyc();
      smp();
      chk("sra.drain", {31'b0, out_valid}, 32'd0);

      // srav over-range boundary 32 then 31
      cyc();
      op(1'b1, 3'b111, 32'd32, 32'hF000_0000, 5'd0);
      cyc();
      op(1'b1, 3'b111, 32'd31, 32'hF000_0000, 5'd0);
      smp();
      chk_out("srav32", 32'hF000_0000, 32'd32, 1'b0, 1'b1, 1'b1);
      cyc();
      op(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0);
      smp();
      chk_out("srav31", 32'hF000_0000, 32'd31, 1'b0, 1'b1, 1'b0);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk_out("srlv_ffff", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
      cyc();
      smp();
      chk("srav.drain", {31'b0, out_valid}, 32'd0);

      // backpressure: fill both entries, third op held
      cyc();
      out_ready = 1'b0;
      op(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hA, 5'd1);
      cyc();
      op(1'b1, 3'b010, 32'd0, 32'hB, 5'd2);
      smp();
      chk("bp.ready1", {31'b0, in_ready}, 32'd1);
      cyc();
      op(1'b1, 3'b100, 32'd3, 32'hC, 5'd31);
      smp();
      chk("bp.full_ready", {31'b0, in_ready}, 32'd0);
      chk_out("bp.hold0", 32'hA, 32'd1, 1'b1, 1'b0, 1'b0);
      cyc();
      smp();
      chk("bp.still_full", {31'b0, in_ready}, 32'd0);
      chk_out("bp.hold1", 32'hA, 32'd1, 1'b1, 1'b0, 1'b0);
      cyc();
      out_ready = 1'b1;
      smp();
      chk_out("bp.out1", 32'hA, 32'd1, 1'b1, 1'b0, 1'b0);
      cyc();
      smp();
      chk("bp.ready_again", {31'b0, in_ready}, 32'd1);
      chk_out("bp.out2", 32'hB, 32'd2, 1'b0, 1'b0, 1'b0);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk_out("bp.out3", 32'hC, 32'd3, 1'b1, 1'b0, 1'b0);
      cyc();
      smp();
      chk("bp.drain", {31'b0, out_valid}, 32'd0);

      // full throughput, 8 ops back to back
      op(1'b1, 3'b000, 32'd0, 32'h100, 5'd0);
      cyc();
      for (int i = 1; i <= 8; i++) begin
         if (i < 8) op(1'b1, 3'b000, 32'd0, 32'h100 + 32'(i), 5'(i));
         else op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
         smp();
         chk($sformatf("tp%0d.valid", i - 1), {31'b0, out_valid}, 32'd1);
         chk($sformatf("tp%0d.a", i - 1), out_a, 32'h100 + 32'(i - 1));
         chk($sformatf("tp%0d.b", i - 1), out_b, 32'(i - 1));
         cyc();
      end
      smp();
      chk("tp.drain", {31'b0, out_valid}, 32'd0);

      // illegal funct 101
      cyc();
      op(1'b1, 3'b101, 32'd40, 32'd5, 5'd7);
      smp();
      chk("ill.pre", {31'b0, illegal}, 32'd0);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk("ill.pulse", {31'b0, illegal}, 32'd1);
      chk("ill.no_out", {31'b0, out_valid}, 32'd0);
      cyc();
      op(1'b1, 3'b100, 32'd5, 32'd1, 5'd0);
      smp();
      chk("ill.end", {31'b0, illegal}, 32'd0);
      chk("ill.no_out2", {31'b0, out_valid}, 32'd0);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk_out("ill.next", 32'd1, 32'd5, 1'b1, 1'b0, 1'b0);
      cyc();

      // reset with two entries buffered
      out_ready = 1'b0;
      op(1'b1, 3'b000, 32'd0, 32'h55, 5'd9);
      cyc();
      op(1'b1, 3'b000, 32'd0, 32'h66, 5'd10);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk("mr.full", {31'b0, in_ready}, 32'd0);
      cyc();
      rst = 1'b1;
      smp();
      chk("mr.in_ready_during", {31'b0, in_ready}, 32'd0);
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;
      smp();
      chk("mr.out_valid", {31'b0, out_valid}, 32'd0);
      chk("mr.in_ready", {31'b0, in_ready}, 32'd1);
      chk("mr.out_b", out_b, 32'd0);
      cyc();
      smp();
      chk("mr.no_stale", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;
      cyc();
      op(1'b1, 3'b010, 32'd0, 32'h77, 5'd12);
      cyc();
      op(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      smp();
      chk("mr.count1", {31'b0, in_ready}, 32'd1);
      chk_out("mr.fresh", 32'h77, 32'd12, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      cyc();
      smp();
      chk("mr.empty", {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
